biu_arb: RTL
============

# biu_arb

Two-master bus interface unit sitting between the core front end (instruction fetch) and back end (load/store) and the single bus transaction port. It arbitrates fetch and load/store requests onto one bus, tracks up to `OST_DEPTH` outstanding transactions in a source-ID FIFO, and routes in-order bus responses back to the issuing master. It supersedes the fetch-only pass-through BIU, adding write support, a lock on stalled grants and bounded outstanding depth.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` strobe bits
- `OST_DEPTH`, 4, max outstanding bus transactions (power of two, >=2)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req_vld` / `if_req_rdy`  in / out  1  fetch request handshake
- `if_req_pc`  in  AW  fetch address (always read)
- `if_rsp_vld` / `if_rsp_rdy`  out / in  1  fetch response handshake
- `if_rsp_ir`  out  DW  fetched instruction word
- `ls_req_vld` / `ls_req_rdy`  in / out  1  load/store request handshake
- `ls_req_cmd`  in  1  0 = read, 1 = write
- `ls_req_addr`  in  AW  load/store address
- `ls_req_wdata`  in  DW  write data
- `ls_req_strb`  in  DW/8  write byte enables
- `ls_rsp_vld` / `ls_rsp_rdy`  out / in  1  load/store response handshake
- `ls_rsp_data`  out  DW  read data (don't-care for writes)
- `bus_req_vld` / `bus_req_rdy`  out / in  1  bus request handshake
- `bus_req_cmd`  out  1  BUS_CMD_READ (0) / BUS_CMD_WRITE (1)
- `bus_req_addr`, `bus_req_wdata`, `bus_req_strb`  out  AW, DW, DW/8
- `bus_rsp_vld` / `bus_rsp_rdy`  in / out  1  bus response handshake
- `bus_rsp_data`  in  DW  response data

## Operation
- Request FSM: `IDLE`, `LOCK`. In `IDLE`, grant chosen combinationally among valid masters; `bus_req_*` driven from granted master; `bus_req_vld` = granted master's vld AND `!full`.
- `IDLE` -> `LOCK` when `bus_req_vld && !bus_req_rdy`; grant registered. In `LOCK`, grant fixed to registered master regardless of other requests; -> `IDLE` on `bus_req_vld && bus_req_rdy`.
- Master rdy: granted master's `*_req_rdy = bus_req_rdy && !full`; non-granted master's rdy = 0.
- Bus request accept pushes source ID (0 = fetch, 1 = ldst) into ID FIFO; writes push too (every transaction gets exactly one response).
- `full` = count == `OST_DEPTH`; full blocks new requests even if a pop occurs the same cycle.
- Response: head ID selects target; `if_rsp_vld = bus_rsp_vld && !empty && head==0`, likewise ldst for head==1; `bus_rsp_rdy` = selected master's rsp_rdy, 0 when FIFO empty (response stalled, never dropped). Handshake pops FIFO.
- `if_rsp_ir` and `ls_rsp_data` both carry `bus_rsp_data` unconditionally.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Count width `$clog2(OST_DEPTH)+1`; pointers `$clog2(OST_DEPTH)` bits, wrap naturally.

## Timing
- Request path and response path: 0-cycle combinational pass-through; no added latency.
- Max throughput: one request and one response per cycle.
- Reset: FSM `IDLE`, FIFO empty, count 0, registered grant 0, round-robin pointer favouring ldst. All valid/ready outputs 0 while `rst` high; data outputs don't-care.
- Reset mid-operation discards outstanding IDs; responses arriving after reset see empty FIFO and are stalled.
- `bus_req_*` stable while `bus_req_vld && !bus_req_rdy` (guaranteed by `LOCK`, provided masters hold their requests).

## Configuration
- `BIU_ARB_RR_EN` defined: round-robin; after each accepted bus request, priority passes to the other master.
- Undefined: fixed priority, ldst always wins over fetch in `IDLE`.

## Test plan
- Fetch only, `if_req_pc`=0x100, bus rdy=1, rsp data 0x00000013 next cycle -> one bus read to 0x100, `if_rsp_ir`=0x00000013, FIFO back to empty.
- Both request same cycle, bus rdy=1: fixed mode -> ldst first then fetch; with `BIU_ARB_RR_EN`, 4 back-to-back pairs alternate ldst, fetch, ldst, fetch.
- Fetch granted, `bus_req_rdy`=0 for 3 cycles while ldst raises vld -> bus keeps fetch address, `ls_req_rdy`=0, fetch accepted cycle 4, ldst next.
- 4 reads issued with no responses (`OST_DEPTH`=4) -> 5th request sees rdy=0; one response with pop same cycle -> request still blocked that cycle, accepted next.
- Interleaved fetch, ldst write (strb 0x3), fetch; responses in order -> routed if, ls, if; ls_rsp asserted for write.
- Assert `rst` with 2 outstanding, then `bus_rsp_vld`=1 -> `bus_rsp_rdy`=0, no master rsp_vld.

Source files
------------

// File: rtl/biu_arb_if.sv
// Bundle of the fetch, load/store and bus handshake signals around biu_arb.
// Pure wiring: no logic and no added latency.
// slave = arbiter-side view, master = the surrounding cores and bus.
interface biu_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_vld;
  logic            if_req_rdy;
  logic [AW-1:0]   if_req_pc;
  logic            if_rsp_vld;
  logic            if_rsp_rdy;
  logic [DW-1:0]   if_rsp_ir;

  logic            ls_req_vld;
  logic            ls_req_rdy;
  logic            ls_req_cmd;
  logic [AW-1:0]   ls_req_addr;
  logic [DW-1:0]   ls_req_wdata;
  logic [DW/8-1:0] ls_req_strb;
  logic            ls_rsp_vld;
  logic            ls_rsp_rdy;
  logic [DW-1:0]   ls_rsp_data;

  logic            bus_req_vld;
  logic            bus_req_rdy;
  logic            bus_req_cmd;
  logic [AW-1:0]   bus_req_addr;
  logic [DW-1:0]   bus_req_wdata;
  logic [DW/8-1:0] bus_req_strb;
  logic            bus_rsp_vld;
  logic            bus_rsp_rdy;
  logic [DW-1:0]   bus_rsp_data;

  modport slave (
    input  if_req_vld, if_req_pc, if_rsp_rdy,
    output if_req_rdy, if_rsp_vld, if_rsp_ir,
    input  ls_req_vld, ls_req_cmd, ls_req_addr, ls_req_wdata, ls_req_strb, ls_rsp_rdy,
    output ls_req_rdy, ls_rsp_vld, ls_rsp_data,
    input  bus_req_rdy, bus_rsp_vld, bus_rsp_data,
    output bus_req_vld, bus_req_cmd, bus_req_addr, bus_req_wdata, bus_req_strb, bus_rsp_rdy
  );

  modport master (
    output if_req_vld, if_req_pc, if_rsp_rdy,
    input  if_req_rdy, if_rsp_vld, if_rsp_ir,
    output ls_req_vld, ls_req_cmd, ls_req_addr, ls_req_wdata, ls_req_strb, ls_rsp_rdy,
    input  ls_req_rdy, ls_rsp_vld, ls_rsp_data,
    output bus_req_rdy, bus_rsp_vld, bus_rsp_data,
    input  bus_req_vld, bus_req_cmd, bus_req_addr, bus_req_wdata, bus_req_strb, bus_rsp_rdy
  );
endinterface

// File: rtl/biu_arb.sv
// Fetch + load/store arbiter onto one bus port, in-order response routing via a source-ID FIFO.
// Latency: 0 cycles on both request and response paths (combinational pass-through).
// Backpressure: stalled grant is locked until accepted; requests blocked when OST_DEPTH outstanding;
// responses stall (never drop) when the target master is not ready or nothing is outstanding.
// BIU_ARB_RR_EN defined: round-robin arbitration; undefined: load/store has fixed priority.
module biu_arb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int OST_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  biu_arb_if.slave io
);
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OST_DEPTH);
  localparam logic BUS_CMD_READ = 1'b0;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;     // 0 = fetch, 1 = load/store
  logic          gnt;
  logic          req_vld;
  logic          rsp_rdy;
  logic          push, pop, full, empty, head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          id_mem [OST_DEPTH];

`ifdef BIU_ARB_RR_EN
  logic          rr_pri_q;         // master favoured on a tie, 1 = load/store
`endif

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = id_mem[rd_ptr_q];

  // Arbitration and next state: choose a master in IDLE, hold the registered one in LOCK.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gnt     = gnt_q;
    if (state_q == IDLE) begin
`ifdef BIU_ARB_RR_EN
      gnt = (io.if_req_vld && io.ls_req_vld) ? rr_pri_q : io.ls_req_vld;
`else
      gnt = io.ls_req_vld;
`endif
    end
    req_vld = !rst && !full && (gnt ? io.ls_req_vld : io.if_req_vld);
    if (state_q == IDLE) begin
      if (req_vld && !io.bus_req_rdy) begin
        state_d = LOCK;
        gnt_d   = gnt;
      end
    end else begin
      if (req_vld && io.bus_req_rdy) state_d = IDLE;
    end
  end

  // Request FSM state and locked grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef BIU_ARB_RR_EN
  // Hand priority to the other master after every accepted bus request.
  always_ff @(posedge clk) begin
    if (rst)       rr_pri_q <= 1'b1;
    else if (push) rr_pri_q <= ~gnt;
  end
`endif

  // Request side: granted master drives the bus; only it may see ready.
  assign io.bus_req_vld   = req_vld;
  assign io.bus_req_cmd   = gnt ? io.ls_req_cmd   : BUS_CMD_READ;
  assign io.bus_req_addr  = gnt ? io.ls_req_addr  : io.if_req_pc;
  assign io.bus_req_wdata = gnt ? io.ls_req_wdata : '0;
  assign io.bus_req_strb  = gnt ? io.ls_req_strb  : '0;
  assign io.if_req_rdy    = !rst && !full && !gnt && io.bus_req_rdy;
  assign io.ls_req_rdy    = !rst && !full &&  gnt && io.bus_req_rdy;

  // Response side: the oldest outstanding source ID picks the destination.
  assign rsp_rdy          = !rst && !empty && (head ? io.ls_rsp_rdy : io.if_rsp_rdy);
  assign io.bus_rsp_rdy   = rsp_rdy;
  assign io.if_rsp_vld    = !rst && !empty && !head && io.bus_rsp_vld;
  assign io.ls_rsp_vld    = !rst && !empty &&  head && io.bus_rsp_vld;
  assign io.if_rsp_ir     = io.bus_rsp_data;
  assign io.ls_rsp_data   = io.bus_rsp_data;

  assign push = req_vld && io.bus_req_rdy;
  assign pop  = io.bus_rsp_vld && rsp_rdy;

  // ID FIFO pointers and occupancy; reset discards anything outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // ID FIFO storage: record which master issued each accepted request.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= gnt;
  end
endmodule
